gpio_bank_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational bidirectional pad ring. It owns per-pin output-data and output-enable registers behind a small config port, and synchronises pad inputs into the core clock domain. It detects input edges into a sticky, maskable interrupt and provides a synchronised test-mode loopback path. It sits between the PADBIDIR instances (pad-side ports) and core logic (core/config/test ports).

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_bank_ctrl_if.sv | 13 +
 rtl/gpio_sync.sv | 20 ++
 rtl/gpio_bank_ctrl.sv | 82 ++++++++
 tb/tb_gpio_bank_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, edge-mode encodings and synchroniser depth limits for the GPIO bank
package gpio_pkg;
    localparam logic [1:0] ADDR_DOUT     = 2'd0;
    localparam logic [1:0] ADDR_OE       = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_STAT = 2'd3;
    localparam int EDGE_RISE       = 0;
    localparam int EDGE_BOTH       = 1;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
endpackage

// File: rtl/gpio_bank_ctrl_if.sv
// gpio_bank_ctrl_if: config read/write port between core logic (master) and the GPIO bank (slave)
interface gpio_bank_ctrl_if #(
    parameter int GPIO_WIDTH = 15
);
    logic                  cfg_wr;
    logic                  cfg_rd;
    logic [1:0]            cfg_addr;
    logic [GPIO_WIDTH-1:0] cfg_wdata;
    logic [GPIO_WIDTH-1:0] cfg_rdata;
    logic                  cfg_rvalid;
    modport master (output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, input cfg_rdata, cfg_rvalid);
    modport slave (input cfg_wr, cfg_rd, cfg_addr, cfg_wdata, output cfg_rdata, cfg_rvalid);
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: N-stage vector synchroniser with synchronous active-low reset
module gpio_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end
    assign q = stage_q[STAGES-1];
endmodule

// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: clocked GPIO bank with output/enable registers, input sync, edge IRQs and test loopback
module gpio_bank_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 15,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpio_bank_ctrl_if.slave       cfg,
    input  logic [GPIO_WIDTH-1:0] pad_y,
    output logic [GPIO_WIDTH-1:0] pad_a,
    output logic [GPIO_WIDTH-1:0] pad_oe,
    output logic [GPIO_WIDTH-1:0] pad_ie,
    input  logic                  tm_y,
    output logic [GPIO_WIDTH-1:0] core_in,
    input  logic [GPIO_WIDTH-1:0] test_in,
    output logic [GPIO_WIDTH-1:0] test_out,
    output logic                  tm_active,
    output logic                  irq
);
    // out-of-range depths are clamped into the legal synchroniser range
    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
    logic [GPIO_WIDTH-1:0] dout_q, dout_d, oe_q, oe_d, irq_en_q, irq_en_d;
    logic [GPIO_WIDTH-1:0] irq_stat_q, irq_stat_d, prev_q, prev_d, rdata_q, rdata_d;
    logic [GPIO_WIDTH-1:0] rise, fall, ev, clr_mask, rd_sel;
    logic                  rvalid_q, rvalid_d, irq_q, irq_d;
    gpio_sync #(.WIDTH(GPIO_WIDTH), .STAGES(SYNC_N)) u_sync_pad (
        .clk(clk), .rst_n(rst_n), .d(pad_y), .q(core_in)
    );
    gpio_sync #(.WIDTH(1), .STAGES(SYNC_N)) u_sync_tm (
        .clk(clk), .rst_n(rst_n), .d(tm_y), .q(tm_active)
    );
    always_comb begin
        rise       = core_in & ~prev_q;
        fall       = ~core_in & prev_q;
        ev         = (EDGE_MODE == EDGE_BOTH) ? (rise | fall) : rise;
        clr_mask   = (cfg.cfg_wr && cfg.cfg_addr == ADDR_IRQ_STAT) ? cfg.cfg_wdata : '0;
        dout_d     = (cfg.cfg_wr && cfg.cfg_addr == ADDR_DOUT) ? cfg.cfg_wdata : dout_q;
        oe_d       = (cfg.cfg_wr && cfg.cfg_addr == ADDR_OE) ? cfg.cfg_wdata : oe_q;
        irq_en_d   = (cfg.cfg_wr && cfg.cfg_addr == ADDR_IRQ_EN) ? cfg.cfg_wdata : irq_en_q;
        // new events win over a same-cycle clear; status is frozen in test mode
        irq_stat_d = (irq_stat_q & ~clr_mask) | (tm_active ? '0 : (ev & irq_en_q));
        irq_d      = |irq_stat_q;
        prev_d     = core_in;
        rd_sel     = (cfg.cfg_addr == ADDR_DOUT)   ? dout_q :
                     (cfg.cfg_addr == ADDR_OE)     ? oe_q :
                     (cfg.cfg_addr == ADDR_IRQ_EN) ? irq_en_q : irq_stat_q;
        rdata_d    = cfg.cfg_rd ? rd_sel : rdata_q;
        rvalid_d   = cfg.cfg_rd;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q     <= '0;
            oe_q       <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            prev_q     <= prev_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end
    assign pad_a          = tm_active ? test_in : dout_q;
    assign pad_oe         = oe_q;
    assign pad_ie         = ~oe_q;
    assign test_out       = tm_active ? core_in : '0;
    assign irq            = irq_q;
    assign cfg.cfg_rdata  = rdata_q;
    assign cfg.cfg_rvalid = rvalid_q;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb_gpio_bank_ctrl: directed checks of a rising-edge bank (dut0) and a both-edge bank (dut1)
module tb_gpio_bank_ctrl;
    localparam int W = 15;
    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] pad_y, test_in;
    logic tm_y;
    logic [W-1:0] pad_a0, pad_oe0, pad_ie0, core_in0, test_out0;
    logic [W-1:0] pad_a1, pad_oe1, pad_ie1, core_in1, test_out1;
    logic tm_active0, irq0, tm_active1, irq1;
    int n_chk = 0;
    int n_fail = 0;
    gpio_bank_ctrl_if #(.GPIO_WIDTH(W)) bus0 ();
    gpio_bank_ctrl_if #(.GPIO_WIDTH(W)) bus1 ();
    gpio_bank_ctrl #(.GPIO_WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg(bus0), .pad_y(pad_y), .pad_a(pad_a0), .pad_oe(pad_oe0),
        .pad_ie(pad_ie0), .tm_y(tm_y), .core_in(core_in0), .test_in(test_in),
        .test_out(test_out0), .tm_active(tm_active0), .irq(irq0)
    );
    gpio_bank_ctrl #(.GPIO_WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg(bus1), .pad_y(pad_y), .pad_a(pad_a1), .pad_oe(pad_oe1),
        .pad_ie(pad_ie1), .tm_y(tm_y), .core_in(core_in1), .test_in(test_in),
        .test_out(test_out1), .tm_active(tm_active1), .irq(irq1)
    );
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input bit s, input logic [1:0] addr, input logic [W-1:0] data);
        if (s) begin bus1.cfg_wr = 1'b1; bus1.cfg_addr = addr; bus1.cfg_wdata = data; end
        else   begin bus0.cfg_wr = 1'b1; bus0.cfg_addr = addr; bus0.cfg_wdata = data; end
        tick(1);
        bus0.cfg_wr = 1'b0;
        bus1.cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input bit s, input logic [1:0] addr);
        if (s) begin bus1.cfg_rd = 1'b1; bus1.cfg_addr = addr; end
        else   begin bus0.cfg_rd = 1'b1; bus0.cfg_addr = addr; end
        tick(1);
        bus0.cfg_rd = 1'b0;
        bus1.cfg_rd = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pad_y = '1; tm_y = 1'b0; test_in = '0;
        bus0.cfg_wr = 0; bus0.cfg_rd = 0; bus0.cfg_addr = 0; bus0.cfg_wdata = 0;
        bus1.cfg_wr = 0; bus1.cfg_rd = 0; bus1.cfg_addr = 0; bus1.cfg_wdata = 0;
        tick(2);
        n_chk++; if (pad_a0 !== 15'h0) begin n_fail++; $display("FAIL reset_pad_a got %h exp 0000", pad_a0); end
        n_chk++; if (pad_oe0 !== 15'h0) begin n_fail++; $display("FAIL reset_pad_oe got %h exp 0000", pad_oe0); end
        n_chk++; if (pad_ie0 !== 15'h7fff) begin n_fail++; $display("FAIL reset_pad_ie got %h exp 7fff", pad_ie0); end
        n_chk++; if (core_in0 !== 15'h0) begin n_fail++; $display("FAIL reset_core_in got %h exp 0000", core_in0); end
        n_chk++; if ({irq0, tm_active0, bus0.cfg_rvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {irq0, tm_active0, bus0.cfg_rvalid}); end
        n_chk++; if (bus0.cfg_rdata !== 15'h0 || test_out0 !== 15'h0) begin n_fail++; $display("FAIL reset_rdata_tout got %h/%h exp 0000/0000", bus0.cfg_rdata, test_out0); end
        n_chk++; if (pad_oe1 !== 15'h0 || pad_ie1 !== 15'h7fff || pad_a1 !== 15'h0) begin n_fail++; $display("FAIL reset_dut1_pads got %h/%h/%h exp 0000/7fff/0000", pad_oe1, pad_ie1, pad_a1); end
        rst_n = 1'b1;
        tick(1);
        n_chk++; if (core_in0 !== 15'h0) begin n_fail++; $display("FAIL sync_latency_1 got %h exp 0000", core_in0); end
        tick(1);
        n_chk++; if (core_in0 !== 15'h7fff || core_in1 !== 15'h7fff) begin n_fail++; $display("FAIL sync_latency_2 got %h/%h exp 7fff/7fff", core_in0, core_in1); end
    endtask

    task automatic test_oe_dout;
        cfg_write(0, 2'd1, 15'h000f);
        cfg_write(0, 2'd0, 15'h0005);
        n_chk++; if (pad_oe0 !== 15'h000f) begin n_fail++; $display("FAIL oe_write got %h exp 000f", pad_oe0); end
        n_chk++; if (pad_a0 !== 15'h0005) begin n_fail++; $display("FAIL dout_write got %h exp 0005", pad_a0); end
        n_chk++; if (pad_ie0 !== 15'h7ff0) begin n_fail++; $display("FAIL pad_ie got %h exp 7ff0", pad_ie0); end
        cfg_read(0, 2'd0);
        n_chk++; if (bus0.cfg_rvalid !== 1'b1 || bus0.cfg_rdata !== 15'h0005) begin n_fail++; $display("FAIL read_dout got %b/%h exp 1/0005", bus0.cfg_rvalid, bus0.cfg_rdata); end
        tick(1);
        n_chk++; if (bus0.cfg_rvalid !== 1'b0 || bus0.cfg_rdata !== 15'h0005) begin n_fail++; $display("FAIL read_hold got %b/%h exp 0/0005", bus0.cfg_rvalid, bus0.cfg_rdata); end
    endtask

    task automatic test_irq;
        pad_y = '0;
        tick(3);
        cfg_write(0, 2'd2, 15'h0002);
        pad_y[1] = 1'b1;
        tick(2);
        bus0.cfg_rd = 1'b1; bus0.cfg_addr = 2'd3;
        tick(1);
        n_chk++; if (bus0.cfg_rdata !== 15'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_stat_early got %h/%b exp 0000/0", bus0.cfg_rdata, irq0); end
        tick(1);
        bus0.cfg_rd = 1'b0;
        n_chk++; if (bus0.cfg_rdata !== 15'h0002 || irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_stat_set got %h/%b exp 0002/1", bus0.cfg_rdata, irq0); end
        pad_y[3] = 1'b1; tick(3);
        pad_y[3] = 1'b0; tick(3);
        cfg_read(0, 2'd3);
        n_chk++; if (bus0.cfg_rdata !== 15'h0002) begin n_fail++; $display("FAIL irq_masked_pin got %h exp 0002", bus0.cfg_rdata); end
    endtask

    task automatic test_w1c;
        pad_y[1] = 1'b0;
        tick(3);
        pad_y[1] = 1'b1;
        tick(2);
        cfg_write(0, 2'd3, 15'h0002);
        cfg_read(0, 2'd3);
        n_chk++; if (bus0.cfg_rdata !== 15'h0002) begin n_fail++; $display("FAIL w1c_set_wins got %h exp 0002", bus0.cfg_rdata); end
        cfg_write(0, 2'd3, 15'h0002);
        n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_lag got %b exp 1", irq0); end
        tick(1);
        n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_clear got %b exp 0", irq0); end
        cfg_read(0, 2'd3);
        n_chk++; if (bus0.cfg_rdata !== 15'h0000) begin n_fail++; $display("FAIL w1c_clear got %h exp 0000", bus0.cfg_rdata); end
    endtask

    task automatic test_test_mode;
        cfg_write(0, 2'd2, 15'h7fff);
        cfg_write(0, 2'd1, 15'h7fff);
        test_in = 15'h0a0a;
        tm_y = 1'b1;
        tick(1);
        n_chk++; if (tm_active0 !== 1'b0 || pad_a0 !== 15'h0005) begin n_fail++; $display("FAIL tm_early got %b/%h exp 0/0005", tm_active0, pad_a0); end
        tick(1);
        n_chk++; if (tm_active0 !== 1'b1 || pad_a0 !== 15'h0a0a) begin n_fail++; $display("FAIL tm_enter got %b/%h exp 1/0a0a", tm_active0, pad_a0); end
        n_chk++; if (test_out0 !== 15'h0002 || pad_oe0 !== 15'h7fff) begin n_fail++; $display("FAIL tm_loop got %h/%h exp 0002/7fff", test_out0, pad_oe0); end
        pad_y = 15'h00f3;
        tick(4);
        n_chk++; if (test_out0 !== 15'h00f3 || test_out1 !== 15'h00f3 || tm_active1 !== 1'b1) begin n_fail++; $display("FAIL tm_track got %h/%h/%b exp 00f3/00f3/1", test_out0, test_out1, tm_active1); end
        cfg_read(0, 2'd3);
        n_chk++; if (bus0.cfg_rdata !== 15'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL tm_irq_frozen got %h/%b exp 0000/0", bus0.cfg_rdata, irq0); end
        tm_y = 1'b0;
        tick(2);
        n_chk++; if (tm_active0 !== 1'b0 || pad_a0 !== 15'h0005 || test_out0 !== 15'h0) begin n_fail++; $display("FAIL tm_exit got %b/%h/%h exp 0/0005/0000", tm_active0, pad_a0, test_out0); end
        cfg_read(0, 2'd0);
        n_chk++; if (bus0.cfg_rdata !== 15'h0005) begin n_fail++; $display("FAIL tm_dout_kept got %h exp 0005", bus0.cfg_rdata); end
    endtask

    task automatic test_back_to_back;
        bus0.cfg_wr = 1'b1; bus0.cfg_rd = 1'b1; bus0.cfg_addr = 2'd0; bus0.cfg_wdata = 15'h1234;
        tick(1);
        bus0.cfg_wr = 1'b0;
        n_chk++; if (bus0.cfg_rdata !== 15'h0005 || pad_a0 !== 15'h1234) begin n_fail++; $display("FAIL rw_same_addr got %h/%h exp 0005/1234", bus0.cfg_rdata, pad_a0); end
        bus0.cfg_addr = 2'd1;
        tick(1);
        n_chk++; if (bus0.cfg_rdata !== 15'h7fff || bus0.cfg_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_read_oe got %h/%b exp 7fff/1", bus0.cfg_rdata, bus0.cfg_rvalid); end
        bus0.cfg_addr = 2'd0;
        tick(1);
        bus0.cfg_rd = 1'b0;
        n_chk++; if (bus0.cfg_rdata !== 15'h1234 || bus0.cfg_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_read_dout got %h/%b exp 1234/1", bus0.cfg_rdata, bus0.cfg_rvalid); end
        tick(1);
        n_chk++; if (bus0.cfg_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_drop got %b exp 0", bus0.cfg_rvalid); end
    endtask

    task automatic test_edge_both_reset;
        cfg_write(1, 2'd2, 15'h0001);
        pad_y[0] = 1'b0;
        tick(4);
        n_chk++; if (irq1 !== 1'b1 || irq0 !== 1'b0) begin n_fail++; $display("FAIL fall_edge_irq got %b/%b exp 1/0", irq1, irq0); end
        cfg_read(1, 2'd3);
        n_chk++; if (bus1.cfg_rdata !== 15'h0001) begin n_fail++; $display("FAIL fall_edge_stat got %h exp 0001", bus1.cfg_rdata); end
        bus1.cfg_rd = 1'b1; bus1.cfg_addr = 2'd3;
        rst_n = 1'b0;
        tick(1);
        bus1.cfg_rd = 1'b0;
        n_chk++; if (irq1 !== 1'b0 || bus1.cfg_rvalid !== 1'b0 || bus1.cfg_rdata !== 15'h0) begin n_fail++; $display("FAIL mid_reset_dut1 got %b/%b/%h exp 0/0/0000", irq1, bus1.cfg_rvalid, bus1.cfg_rdata); end
        n_chk++; if (pad_oe0 !== 15'h0 || pad_ie0 !== 15'h7fff || pad_a0 !== 15'h0 || core_in0 !== 15'h0) begin n_fail++; $display("FAIL mid_reset_dut0 got %h/%h/%h/%h exp 0000/7fff/0000/0000", pad_oe0, pad_ie0, pad_a0, core_in0); end
        rst_n = 1'b1;
        tick(3);
        cfg_read(1, 2'd3);
        n_chk++; if (bus1.cfg_rdata !== 15'h0 || irq1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_stat got %h/%b exp 0000/0", bus1.cfg_rdata, irq1); end
    endtask

    initial begin
        test_reset();
        test_oe_dout();
        test_irq();
        test_w1c();
        test_test_mode();
        test_back_to_back();
        test_edge_both_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
